// File: rtl/wbck_sched_pkg.sv
// Shared definitions for the writeback scheduler: requester ids, default
// widths and the round-robin successor helper.
package wbck_sched_pkg;

   localparam int WBCK_XLEN_DFLT    = 32;
   localparam int WBCK_RFIDX_W_DFLT = 5;

   // Requester ids double as grant-vector bit positions.
   typedef enum logic [1:0] {
      WBCK_ALU    = 2'd0,
      WBCK_LSU    = 2'd1,
      WBCK_MULDIV = 2'd2
   } wbck_req_e;

   function automatic wbck_req_e rr_next(wbck_req_e r);
      case (r)
         WBCK_ALU: return WBCK_LSU;
         WBCK_LSU: return WBCK_MULDIV;
         default:  return WBCK_ALU;
      endcase
   endfunction

endpackage

// File: rtl/wbck_sched_rr_arb.sv
// 3-way round-robin arbiter. Grants the first valid requester at or after the
// pointer, in order ALU, LSU, MULDIV with wrap, and moves the pointer past the
// winner. Grants are forced low while reset is asserted.
//
//   state (r_ptr) | meaning
//   WBCK_ALU      | ALU has top priority, then LSU, then MULDIV
//   WBCK_LSU      | LSU has top priority, then MULDIV, then ALU
//   WBCK_MULDIV   | MULDIV has top priority, then ALU, then LSU
module wbck_rr_arb
   import wbck_sched_pkg::*;
#(
   parameter int RR_INIT = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] i_vld,
   output logic [2:0] o_gnt
);

   localparam wbck_req_e LP_PTR_INIT = wbck_req_e'(2'(RR_INIT));

   wbck_req_e r_ptr;
   wbck_req_e w_ptr_nxt;
   wbck_req_e w_idx;
   logic      w_hit;
   logic [2:0] w_gnt;

   // Priority pointer register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ptr <= LP_PTR_INIT;
      else        r_ptr <= w_ptr_nxt;
   end

   // Scan from the pointer with wrap; first valid wins, pointer moves past it
   always_comb begin
      w_gnt     = 3'b000;
      w_ptr_nxt = r_ptr;
      w_idx     = r_ptr;
      w_hit     = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (!w_hit && i_vld[w_idx]) begin
            w_gnt[w_idx] = 1'b1;
            w_hit        = 1'b1;
            w_ptr_nxt    = rr_next(w_idx);
         end
         w_idx = rr_next(w_idx);
      end
   end

   assign o_gnt = rst_n ? w_gnt : 3'b000;

endmodule

// File: rtl/wbck_sched.sv
// Writeback scheduler: arbitrates ALU/LSU/MULDIV results onto the single
// regfile write port and tracks outstanding long-pipe destinations so that
// dispatch can stall on RAW/WAW hazards.
module wbck_sched
   import wbck_sched_pkg::*;
#(
   parameter int XLEN    = WBCK_XLEN_DFLT,
   parameter int RFIDX_W = WBCK_RFIDX_W_DFLT,
   parameter int RR_INIT = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               alu_wbck_vld,
   output logic               alu_wbck_rdy,
   input  logic [RFIDX_W-1:0] alu_wbck_rd,
   input  logic               alu_wbck_wen,
   input  logic [XLEN-1:0]    alu_wbck_data,
   input  logic               lsu_wbck_vld,
   output logic               lsu_wbck_rdy,
   input  logic [RFIDX_W-1:0] lsu_wbck_rd,
   input  logic               lsu_wbck_wen,
   input  logic [XLEN-1:0]    lsu_wbck_data,
   input  logic               muldiv_wbck_vld,
   output logic               muldiv_wbck_rdy,
   input  logic [RFIDX_W-1:0] muldiv_wbck_rd,
   input  logic               muldiv_wbck_wen,
   input  logic [XLEN-1:0]    muldiv_wbck_data,
   input  logic               longp_disp_vld,
   input  logic [RFIDX_W-1:0] longp_disp_rd,
   input  logic               longp_disp_wen,
   input  logic               dec_rs1_en,
   input  logic [RFIDX_W-1:0] dec_rs1_idx,
   input  logic               dec_rs2_en,
   input  logic [RFIDX_W-1:0] dec_rs2_idx,
   input  logic               dec_rd_en,
   input  logic [RFIDX_W-1:0] dec_rd_idx,
   output logic               dep_stall,
   output logic               rf_wen,
   output logic [RFIDX_W-1:0] rf_waddr,
   output logic [XLEN-1:0]    rf_wdata
);

   localparam int NREG = 2 ** RFIDX_W;

   logic [2:0]         w_vld;
   logic [2:0]         w_gnt;
   logic               w_sel_wen;
   logic [RFIDX_W-1:0] w_sel_rd;
   logic [XLEN-1:0]    w_sel_data;
   logic [NREG-1:0]    w_clr;
   logic [NREG-1:0]    w_set;
   logic [NREG-1:0]    w_pend_nxt;

   logic [NREG-1:0]    r_pend;
   logic               r_rf_wen;
   logic [RFIDX_W-1:0] r_rf_waddr;
   logic [XLEN-1:0]    r_rf_wdata;

   assign w_vld = {muldiv_wbck_vld, lsu_wbck_vld, alu_wbck_vld};

   wbck_rr_arb #(
      .RR_INIT (RR_INIT)
   ) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .i_vld (w_vld),
      .o_gnt (w_gnt)
   );

   assign alu_wbck_rdy    = w_gnt[WBCK_ALU];
   assign lsu_wbck_rdy    = w_gnt[WBCK_LSU];
   assign muldiv_wbck_rdy = w_gnt[WBCK_MULDIV];

   // Select the granted channel's write fields (grant is one-hot)
   always_comb begin
      w_sel_wen  = 1'b0;
      w_sel_rd   = '0;
      w_sel_data = '0;
      if (w_gnt[WBCK_ALU]) begin
         w_sel_wen  = alu_wbck_wen;
         w_sel_rd   = alu_wbck_rd;
         w_sel_data = alu_wbck_data;
      end else if (w_gnt[WBCK_LSU]) begin
         w_sel_wen  = lsu_wbck_wen;
         w_sel_rd   = lsu_wbck_rd;
         w_sel_data = lsu_wbck_data;
      end else if (w_gnt[WBCK_MULDIV]) begin
         w_sel_wen  = muldiv_wbck_wen;
         w_sel_rd   = muldiv_wbck_rd;
         w_sel_data = muldiv_wbck_data;
      end
   end

   // Registered write port; address/data hold when nothing is granted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rf_wen   <= 1'b0;
         r_rf_waddr <= '0;
         r_rf_wdata <= '0;
      end else if (|w_gnt) begin
         r_rf_wen   <= w_sel_wen;
         r_rf_waddr <= w_sel_rd;
         r_rf_wdata <= w_sel_data;
      end else begin
         r_rf_wen   <= 1'b0;
      end
   end

   // Scoreboard update: long-pipe writebacks clear, long-pipe dispatch sets;
   // set is applied last so a new op on the same rd stays outstanding
   always_comb begin
      w_clr = '0;
      w_set = '0;
      if (w_gnt[WBCK_LSU])    w_clr[lsu_wbck_rd]    = 1'b1;
      if (w_gnt[WBCK_MULDIV]) w_clr[muldiv_wbck_rd] = 1'b1;
      if (longp_disp_vld && longp_disp_wen && (longp_disp_rd != '0))
         w_set[longp_disp_rd] = 1'b1;
      w_pend_nxt    = (r_pend & ~w_clr) | w_set;
      w_pend_nxt[0] = 1'b0;
   end

   // Scoreboard register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_pend <= '0;
      else        r_pend <= w_pend_nxt;
   end

   assign dep_stall = (dec_rs1_en & r_pend[dec_rs1_idx])
                    | (dec_rs2_en & r_pend[dec_rs2_idx])
                    | (dec_rd_en  & r_pend[dec_rd_idx]);

   assign rf_wen   = r_rf_wen;
   assign rf_waddr = r_rf_waddr;
   assign rf_wdata = r_rf_wdata;

endmodule
